pipe_stage_skid: RTL

Parametrised pipeline-stage register that succeeds the fixed IF/ID latch. It carries an arbitrary-width payload (for example inst|pc|pcPlus4 = 96 bits) between two pipeline stages using a valid/ready handshake. It adds stall absorption through a 2-entry skid buffer, synchronous flush with bubble injection, an occupancy output and a saturating stall-cycle counter. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB in the next-generation core.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_stall_counter.sv | 29 ++
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers.
// The IF/ID payload is packed as {inst, pc, pc_plus4}, with inst in the MSBs.
// The default bubble is a NOP (addi x0,x0,0) with both PCs zeroed. Downstream
// decoders therefore see a harmless instruction whenever a stage is empty.
package pipe_pkg;

  localparam int INST_W   = 32;
  localparam int PC_W     = 32;
  localparam int IFID_W   = INST_W + 2 * PC_W;

  // Field offsets inside the IF/ID payload.
  localparam int INST_LSB = 2 * PC_W;
  localparam int PC_LSB   = PC_W;
  localparam int PC4_LSB  = 0;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  localparam logic [IFID_W-1:0] BUBBLE_DATA_DEFAULT = {NOP_INST, {(2 * PC_W){1'b0}}};

  // Packs the three IF/ID fields into one payload word.
  function automatic logic [IFID_W-1:0] pack_ifid(input logic [INST_W-1:0] inst,
                                                   input logic [PC_W-1:0]   pc,
                                                   input logic [PC_W-1:0]   pc_plus4);
    return {inst, pc, pc_plus4};
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter. It counts the cycles in which inc is high. Once it
// reaches all-ones it holds that value. Only reset clears it.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears the count
//   inc    count-enable for this cycle
//   cnt    current count (CNT_W bits)
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake on both sides.
// SKID=1: two entries (main M and skid S), and in_ready is registered (!s_valid).
//         No combinational path runs from out_ready to in_ready.
// SKID=0: one entry. in_ready = !m_valid || out_ready, which is combinational.
// flush kills every held entry on the next edge. It also discards any payload
// accepted in the same cycle. An output transfer in that cycle still completes.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload (bubble when empty)
//   flush                 synchronous kill of held entries
//   occupancy             number of held entries (0..2)
//   stall_cnt             saturating count of cycles with out_valid && !out_ready
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = IFID_W,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(BUBBLE_DATA_DEFAULT),
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic              in_fire;
  logic              out_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid && out_ready;
  assign out_valid = m_valid;
  // The data registers are not cleared on flush. This mask produces the bubble.
  assign out_data  = m_valid ? m_data : BUBBLE_DATA;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] s_data;
      logic              m_valid_d;
      logic              s_valid_d;
      logic              m_we;
      logic              s_we;
      logic [DATA_W-1:0] m_wdata;

      // S holds data only while M stalls, so a free S means one more beat fits.
      assign in_ready = !s_valid;

      always_comb begin
        m_valid_d = m_valid;
        s_valid_d = s_valid;
        m_we      = 1'b0;
        s_we      = 1'b0;
        m_wdata   = in_data;
        if (flush) begin
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
        end else if (!m_valid) begin
          // S is never occupied while M is empty.
          if (in_fire) begin
            m_valid_d = 1'b1;
            m_we      = 1'b1;
          end
        end else if (out_fire) begin
          if (s_valid) begin
            // The older skid entry advances. in_ready was low, so no in_fire.
            s_valid_d = 1'b0;
            m_we      = 1'b1;
            m_wdata   = s_data;
          end else if (in_fire) begin
            m_we      = 1'b1;
          end else begin
            m_valid_d = 1'b0;
          end
        end else if (in_fire) begin
          s_valid_d = 1'b1;
          s_we      = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
          m_data  <= BUBBLE_DATA;
          s_data  <= BUBBLE_DATA;
        end else begin
          m_valid <= m_valid_d;
          s_valid <= s_valid_d;
          if (m_we) m_data <= m_wdata;
          if (s_we) s_data <= in_data;
        end
      end
    end else begin : g_flat
      assign s_valid  = 1'b0;
      assign in_ready = !m_valid || out_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          m_valid <= 1'b0;
          m_data  <= BUBBLE_DATA;
        end else begin
          if (flush) begin
            m_valid <= 1'b0;
          end else if (in_fire) begin
            m_valid <= 1'b1;
          end else if (out_fire) begin
            m_valid <= 1'b0;
          end
          if (in_fire && !flush) m_data <= in_data;
        end
      end
    end
  endgenerate

  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (m_valid && !out_ready),
    .cnt  (stall_cnt)
  );

endmodule
